// File: rtl/mem_fetch_seq.sv
// Memory-access sequencer with IR/MDR latches: turns level memory strobes into a req/ack transfer and stalls the controller.
// Optional bus watchdog enabled by defining MEM_WDOG_EN.
module mem_fetch_seq #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              ior_d,
  input  logic              ir_write,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] ir,
  output logic [5:0]        op,
  output logic [DATA_W-1:0] mdr,
  output logic              align_err,
  output logic              bus_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : gBadTimeout
    $error("mem_fetch_seq: TIMEOUT must be in 1..65535");
  end

  logic [1:0]        state;
  logic [1:0]        nextState;
  logic              issue;
  logic              finish;
  logic              abort;
  logic              irWrPend;
  logic [ADDR_W-1:0] addrSel;

  assign addrSel = ior_d ? alu_out : pc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state and transfer-event decode
  always_comb begin
    nextState = state;
    issue     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_rd || mem_wr) begin
          issue     = 1'b1;
          nextState = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          finish    = 1'b1;
          nextState = DONE;
        end else if (abort) begin
          nextState = DONE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Controller holds while a request is being issued or is in flight
  assign stall = ~rst & (issue | (state == BUSY));

  assign op = ir[31:26];

  // Bus request registers and IR/MDR latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      irWrPend  <= 1'b0;
      align_err <= 1'b0;
      ir        <= '0;
      mdr       <= '0;
    end else begin
      align_err <= 1'b0;
      if (issue) begin
        mem_req   <= 1'b1;
        mem_we    <= mem_wr;
        mem_addr  <= {addrSel[ADDR_W-1:2], 2'b00};
        mem_wdata <= wdata;
        irWrPend  <= ir_write & ~mem_wr;
        align_err <= |addrSel[1:0];
      end
      if (finish) begin
        mem_req <= 1'b0;
        if (!mem_we) begin
          mdr <= mem_rdata;
          if (irWrPend) ir <= mem_rdata;
        end
      end
      if (abort) mem_req <= 1'b0;
    end
  end

`ifdef MEM_WDOG_EN
  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

  logic [15:0] wdogCnt;
  logic [15:0] wdogInc;

  assign wdogInc = wdogCnt + 16'd1;
  // Ack in the same cycle as expiry takes precedence
  assign abort   = (state == BUSY) & ~mem_ack & (wdogInc == TimeoutCnt);

  // Counts BUSY cycles without ack; cleared on each new request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdogCnt <= 16'd0;
    end else if (issue) begin
      wdogCnt <= 16'd0;
    end else if (state == BUSY && !mem_ack) begin
      wdogCnt <= wdogInc;
    end
  end

  // Sticky abort flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        bus_err <= 1'b0;
    else if (abort) bus_err <= 1'b1;
  end
`else
  assign abort   = 1'b0;
  assign bus_err = 1'b0;
`endif

endmodule
